// File: rtl/ysyx_23060184_lsu_pkg.sv
// Shared encodings for the LSU: decode's Ropcode/Wmask values, LSU state codes,
// and the alignment rule used when YSYX_23060184_LSU_ALIGN_CHECK_EN is defined.
package ysyx_23060184_lsu_pkg;

  localparam logic [2:0] READ_NONE  = 3'd0;
  localparam logic [2:0] READ_WORD  = 3'd1;
  localparam logic [2:0] READ_HALF  = 3'd2;
  localparam logic [2:0] READ_BYTE  = 3'd3;
  localparam logic [2:0] READ_HALFU = 3'd4;
  localparam logic [2:0] READ_BYTEU = 3'd5;

  localparam logic [1:0] WRITE_NONE = 2'd0;
  localparam logic [1:0] WRITE_WORD = 2'd1;
  localparam logic [1:0] WRITE_HALF = 2'd2;
  localparam logic [1:0] WRITE_BYTE = 2'd3;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // Half accesses need an even address, word accesses a multiple of four.
  function automatic logic misaligned(input logic       is_read,
                                      input logic [2:0] ropcode,
                                      input logic [1:0] wmask,
                                      input logic [1:0] off);
    logic m;
    m = 1'b0;
    if (is_read) begin
      case (ropcode)
        READ_WORD:              m = (off != 2'd0);
        READ_HALF, READ_HALFU:  m = off[0];
        default:                m = 1'b0;
      endcase
    end else begin
      case (wmask)
        WRITE_WORD: m = (off != 2'd0);
        WRITE_HALF: m = off[0];
        default:    m = 1'b0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ysyx_23060184_load_align.sv
// Selects the addressed byte/half from a bus word and sign- or zero-extends it.
module ysyx_23060184_load_align
  import ysyx_23060184_lsu_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  offset,
  input  logic [2:0]  Ropcode,
  output logic [31:0] rdata
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = data[7:0];
    case (offset)
      2'd0: b = data[7:0];
      2'd1: b = data[15:8];
      2'd2: b = data[23:16];
      2'd3: b = data[31:24];
      default: b = data[7:0];
    endcase
    h = offset[1] ? data[31:16] : data[15:0];

    rdata = data;
    case (Ropcode)
      READ_BYTE:  rdata = {{24{b[7]}}, b};
      READ_BYTEU: rdata = {24'd0, b};
      READ_HALF:  rdata = {{16{h[15]}}, h};
      READ_HALFU: rdata = {16'd0, h};
      default:    rdata = data;
    endcase
  end

endmodule

// File: rtl/ysyx_23060184_lsu.sv
// Blocking single-outstanding load/store unit with response timeout.
// Optional misalignment faulting: define YSYX_23060184_LSU_ALIGN_CHECK_EN.
module ysyx_23060184_lsu
  import ysyx_23060184_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Ropcode,
  input  logic [1:0]  Wmask,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done_valid,
  input  logic        done_ready,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready,
  input  logic [31:0] mem_resp_data,
  input  logic        mem_resp_err,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; a valid, once raised, holds its payload stable until that edge.

  lsu_state_e  state, state_nx;
  logic        op_read, op_write;
  logic [2:0]  op_rop;
  logic [1:0]  op_wmask;
  logic [31:0] op_addr, op_wdata;
  logic [31:0] cnt;
  logic [31:0] rdata_q;
  logic        fault_q;
  logic [31:0] load_data;
  logic        misal;
  logic        timeout;

`ifdef YSYX_23060184_LSU_ALIGN_CHECK_EN
  assign misal = (MemRead ^ MemWrite) && misaligned(MemRead, Ropcode, Wmask, addr[1:0]);
`else
  assign misal = 1'b0;
`endif

  assign timeout = (TIMEOUT_CYCLES != 0) &&
                   ((state == LSU_REQ) || (state == LSU_WAIT)) &&
                   (cnt == TIMEOUT_CYCLES - 1);

  ysyx_23060184_load_align u_align (
    .data    (mem_resp_data),
    .offset  (op_addr[1:0]),
    .Ropcode (op_rop),
    .rdata   (load_data)
  );

  always_comb begin
    state_nx = state;
    case (state)
      LSU_IDLE: if (req_valid) state_nx = ((MemRead ^ MemWrite) && !misal) ? LSU_REQ : LSU_DONE;
      LSU_REQ:  if (timeout) state_nx = LSU_DONE;
                else if (mem_req_ready) state_nx = LSU_WAIT;
      // A response landing on the timeout cycle still wins.
      LSU_WAIT: if (mem_resp_valid || timeout) state_nx = LSU_DONE;
      LSU_DONE: if (done_ready) state_nx = LSU_IDLE;
      default:  state_nx = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LSU_IDLE;
      op_read  <= 1'b0;
      op_write <= 1'b0;
      op_rop   <= READ_NONE;
      op_wmask <= WRITE_NONE;
      op_addr  <= '0;
      op_wdata <= '0;
      cnt      <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        LSU_IDLE: if (req_valid) begin
          op_read  <= MemRead & ~MemWrite;
          op_write <= MemWrite & ~MemRead;
          op_rop   <= Ropcode;
          op_wmask <= Wmask;
          op_addr  <= addr;
          op_wdata <= wdata;
          cnt      <= '0;
          rdata_q  <= '0;
          fault_q  <= (MemRead & MemWrite) | misal;
        end
        LSU_REQ: begin
          cnt <= cnt + 32'd1;
          if (timeout) fault_q <= 1'b1;
        end
        LSU_WAIT: begin
          cnt <= cnt + 32'd1;
          if (mem_resp_valid) begin
            rdata_q <= op_read ? load_data : '0;
            fault_q <= mem_resp_err;
          end else if (timeout) begin
            fault_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_wdata = op_wdata;
    mem_wstrb = 4'b0000;
    if (op_write) begin
      case (op_wmask)
        WRITE_WORD: mem_wstrb = 4'b1111;
        WRITE_HALF: begin
          mem_wdata = {2{op_wdata[15:0]}};
          mem_wstrb = 4'b0011 << {op_addr[1], 1'b0};
        end
        WRITE_BYTE: begin
          mem_wdata = {4{op_wdata[7:0]}};
          mem_wstrb = 4'b0001 << op_addr[1:0];
        end
        default: mem_wstrb = 4'b0000;
      endcase
    end
  end

  assign req_ready      = (state == LSU_IDLE);
  assign mem_req_valid  = (state == LSU_REQ);
  assign mem_resp_ready = (state == LSU_WAIT);
  assign done_valid     = (state == LSU_DONE);
  assign mem_wen        = op_write;
  assign mem_addr       = {op_addr[31:2], 2'b00};
  assign rdata          = rdata_q;
  assign fault          = fault_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_ysyx_23060184_lsu.sv
// Randomized bench for ysyx_23060184_lsu against a behavioural model of the
// load/store rules, bus stalls and the response timeout.
module tb_ysyx_23060184_lsu;
  import ysyx_23060184_lsu_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [2:0]  Ropcode = 3'd0;
  logic [1:0]  Wmask = 2'd0;
  logic [31:0] addr = '0, wdata = '0;
  logic        done_valid;
  logic        done_ready = 1'b0;
  logic [31:0] rdata;
  logic        fault;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid = 1'b0;
  logic        mem_resp_ready;
  logic [31:0] mem_resp_data = '0;
  logic        mem_resp_err = 1'b0;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic        exp_fault_q[$];

  ysyx_23060184_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .Ropcode(Ropcode), .Wmask(Wmask),
    .addr(addr), .wdata(wdata),
    .done_valid(done_valid), .done_ready(done_ready),
    .rdata(rdata), .fault(fault),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model ----
  function automatic logic [31:0] model_load(input logic [2:0] rop, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [31:0] v;
    int sh_b, sh_h;
    sh_b = 8 * int'(a[1:0]);
    sh_h = a[1] ? 16 : 0;
    case (rop)
      3'd2: begin v = (w >> sh_h) & 32'hFFFF; if (v[15]) v = v | 32'hFFFF_0000; end
      3'd4: v = (w >> sh_h) & 32'hFFFF;
      3'd3: begin v = (w >> sh_b) & 32'hFF; if (v[7]) v = v | 32'hFFFF_FF00; end
      3'd5: v = (w >> sh_b) & 32'hFF;
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] model_strb(input logic [1:0] wm, input logic [31:0] a);
    case (wm)
      2'd1: return 4'hF;
      2'd2: return a[1] ? 4'b1100 : 4'b0011;
      2'd3: return 4'(1 << a[1:0]);
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] wm, input logic [31:0] w);
    case (wm)
      2'd2: return {w[15:0], w[15:0]};
      2'd3: return {w[7:0], w[7:0], w[7:0], w[7:0]};
      default: return w;
    endcase
  endfunction

  function automatic bit model_misal(input bit rd, input logic [2:0] rop, input logic [1:0] wm,
                                     input logic [31:0] a);
`ifdef YSYX_23060184_LSU_ALIGN_CHECK_EN
    if (rd) return (rop == 3'd1 && a[1:0] != 0) || ((rop == 3'd2 || rop == 3'd4) && a[0]);
    return (wm == 2'd1 && a[1:0] != 0) || (wm == 2'd2 && a[0]);
`else
    return 1'b0;
`endif
  endfunction

  // ---- driver: one operation, bus responder, completion check ----
  task automatic do_op(input bit rd, input bit wr, input logic [2:0] rop, input logic [1:0] wm,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] resp,
                       input bit err, input int r, input int d, input int hold);
    bit bus, tmo, first;
    int exp_cyc, cyc, req_cnt, wait_cnt;
    logic [31:0] got_rd, e_rd;
    logic e_f;
    bus = (rd ^ wr) && !model_misal(rd, rop, wm, a);
    tmo = 1'b0;
    if (!bus) begin
      exp_cyc = 1;
      exp_q.push_back(32'd0);
      exp_fault_q.push_back((rd & wr) | model_misal(rd, rop, wm, a));
    end else if (r + d + 2 <= TO) begin
      exp_cyc = r + d + 3;
      exp_q.push_back(rd ? model_load(rop, a, resp) : 32'd0);
      exp_fault_q.push_back(err);
    end else begin
      tmo = 1'b1;
      exp_cyc = TO + 1;
      exp_q.push_back(32'd0);
      exp_fault_q.push_back(1'b1);
    end

    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; MemRead = rd; MemWrite = wr; Ropcode = rop; Wmask = wm;
    addr = a; wdata = wd;
    cyc = 0; req_cnt = 0; wait_cnt = 0; first = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      req_valid = 1'b0;
      if (done_valid) break;
      if (cyc > 40) begin
        check("done_timeout", 32'(done_valid), 32'd1);
        break;
      end
      if (!bus) check("no_bus_req", 32'(mem_req_valid), 32'd0);
      if (mem_req_valid) begin
        check("mem_addr", mem_addr, {a[31:2], 2'b00});
        check("mem_wen", 32'(mem_wen), 32'(wr));
        check("mem_wstrb", 32'(mem_wstrb), wr ? 32'(model_strb(wm, a)) : 32'd0);
        if (wr && first) check("mem_wdata", mem_wdata, model_wdata(wm, wd));
        first = 1'b0;
        mem_req_ready = (req_cnt == r);
        req_cnt++;
      end else begin
        mem_req_ready = 1'b0;
      end
      if (mem_resp_ready) begin
        mem_resp_valid = (wait_cnt == d);
        mem_resp_data = resp;
        mem_resp_err = err;
        wait_cnt++;
      end else begin
        mem_resp_valid = 1'b0;
      end
    end
    mem_req_ready = 1'b0;
    // a straggling response during DONE must be refused
    mem_resp_valid = tmo;
    mem_resp_data = ~resp;
    mem_resp_err = 1'b0;

    e_rd = exp_q.pop_front();
    e_f  = exp_fault_q.pop_front();
    check("done_latency", 32'(cyc), 32'(exp_cyc));
    check("rdata", rdata, e_rd);
    check("fault", 32'(fault), 32'(e_f));
    check("req_valid_in_done", 32'(mem_req_valid), 32'd0);
    check("resp_ready_in_done", 32'(mem_resp_ready), 32'd0);
    got_rd = rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("done_hold", 32'(done_valid), 32'd1);
      check("rdata_hold", rdata, got_rd);
    end
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    mem_resp_valid = 1'b0;
    check("done_consumed", 32'(done_valid), 32'd0);
    check("req_ready_after", 32'(req_ready), 32'd1);
  endtask

  task automatic reset_in_wait();
    req_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Ropcode = 3'd1; Wmask = 2'd0;
    addr = 32'h40; wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    check("rst_reach_wait", 32'(mem_resp_ready), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_idle", 32'(dbg_state), 32'(LSU_IDLE));
    check("rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_no_done", 32'(done_valid), 32'd0);
      check("rst_no_req", 32'(mem_req_valid), 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'(LSU_IDLE));
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_done_valid", 32'(done_valid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_mem_wen", 32'(mem_wen), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_mem_resp_ready", 32'(mem_resp_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed cases
    do_op(1, 0, 3'd1, 2'd0, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    do_op(1, 0, 3'd3, 2'd0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 0, 0, 1);
    do_op(1, 0, 3'd5, 2'd0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 0, 0, 0);
    do_op(0, 1, 3'd0, 2'd2, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 0, 0, 0, 0);
    do_op(1, 0, 3'd1, 2'd0, 32'h0000_0010, 32'h0, 32'h1111_2222, 1, 3, 0, 0);
    do_op(1, 0, 3'd1, 2'd0, 32'h0000_0020, 32'h0, 32'h3333_4444, 0, 0, 2, 0);
    do_op(1, 0, 3'd1, 2'd0, 32'h0000_0030, 32'h0, 32'h5555_6666, 0, 0, 20, 2);
    do_op(1, 0, 3'd1, 2'd0, 32'h0000_0002, 32'h0, 32'h7777_8888, 0, 0, 0, 0);
    do_op(0, 0, 3'd0, 2'd0, 32'h0000_0040, 32'h0, 32'h0, 0, 0, 0, 0);
    do_op(1, 1, 3'd1, 2'd1, 32'h0000_0044, 32'h0, 32'h0, 0, 0, 0, 1);
    reset_in_wait();

    // randomized operations
    for (int n = 0; n < 200; n++) begin
      int kind;
      bit rd, wr;
      logic [2:0] rop;
      logic [1:0] wm;
      kind = $urandom_range(0, 11);
      rd = 0; wr = 0; rop = 3'd0; wm = 2'd0;
      if (kind == 1) begin rd = 1; wr = 1; rop = 3'($urandom_range(1, 5)); wm = 2'($urandom_range(1, 3)); end
      else if (kind >= 2 && kind <= 6) begin rd = 1; rop = 3'($urandom_range(1, 5)); end
      else if (kind >= 7) begin wr = 1; wm = 2'($urandom_range(1, 3)); end
      do_op(rd, wr, rop, wm, $urandom, $urandom, $urandom,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0) ? 3 : $urandom_range(0, 1),
            $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060184_lsu.md
# ysyx_23060184_lsu

Load/store unit between the decode/execute stage and the data-memory bus. It accepts one memory operation per handshake, using the MemRead/MemWrite/Ropcode/Wmask controls produced by decode. It turns each operation into a word-aligned bus transaction with byte strobes, then returns sign- or zero-extended load data or a write completion to the write-back side. It is the consumer end of the decoder's memory-control interface. It is a blocking, single-outstanding engine with a response timeout.

## Interface
- TIMEOUT_CYCLES, 255: cycles allowed from entering REQ until the response arrives; 0 disables the timeout.
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  operation offered by the upstream stage.
- req_ready  out  1  LSU can accept; high only in IDLE.
- MemRead  in  1  load operation.
- MemWrite  in  1  store operation.
- Ropcode  in  3  load kind: 0 none, 1 WORD, 2 HALF, 3 BYTE, 4 HALFU, 5 BYTEU.
- Wmask  in  2  store kind: 0 none, 1 WORD, 2 HALF, 3 BYTE.
- addr  in  32  byte address from the ALU.
- wdata  in  32  store data (rs2).
- done_valid  out  1  result available.
- done_ready  in  1  downstream takes the result.
- rdata  out  32  extended load data; 0 for stores.
- fault  out  1  access error for this operation.
- mem_req_valid  out  1  bus request.
- mem_req_ready  in  1  bus accepts the request.
- mem_wen  out  1  1 = write.
- mem_addr  out  32  {addr[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte strobes; 0 for reads.
- mem_resp_valid  in  1  bus response.
- mem_resp_ready  out  1  high only in WAIT.
- mem_resp_data  in  32  read word.
- mem_resp_err  in  1  bus error.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: req_ready=1. On req_valid, latch all inputs, then branch on the operation:
  - MemRead^MemWrite: go to REQ.
  - Neither MemRead nor MemWrite: go to DONE with rdata=0, fault=0.
  - Both MemRead and MemWrite: go to DONE with fault=1.
- REQ: mem_req_valid=1, held stable until mem_req_ready, then go to WAIT.
- WAIT: mem_resp_ready=1. On mem_resp_valid, capture the formatted data into rdata, set fault=mem_resp_err, and go to DONE.
- DONE: done_valid=1, with rdata/fault held until done_ready, then go to IDLE.
- Store lanes (o = addr[1:0]):
  - BYTE: wdata={4{wdata[7:0]}}, wstrb=4'b0001<<o.
  - HALF: wdata={2{wdata[15:0]}}, wstrb=4'b0011<<{addr[1],1'b0}.
  - WORD: wstrb=4'b1111.
- Loads:
  - BYTE/BYTEU: resp>>(8*o), then sign- or zero-extend bit 7.
  - HALF/HALFU: resp>>(16*addr[1]), then extend bit 15.
  - WORD: unchanged.
- Timeout: a counter clears on IDLE→REQ and increments each cycle in REQ/WAIT. At TIMEOUT_CYCLES it forces DONE with fault=1 and rdata=0, and drops mem_req_valid. A response arriving later is ignored, since mem_resp_ready=0 outside WAIT.
- Reset mid-operation: returns to IDLE immediately. Any pending bus transaction is abandoned, with no completion emitted.

## Timing
- Reset values: state IDLE, req_ready=1; every other output 0 (rdata=0, fault=0, mem_* = 0, done_valid=0).
- Outputs are registered-state decodes; there is no combinational path from req_valid to any mem_* signal.
- Best case: accept at cycle 0; mem_req_valid in cycle 1; mem_req_ready in cycle 1; mem_resp_valid in cycle 2; done_valid in cycle 3. Load-to-result latency is 3 cycles plus bus stalls.
- Idle-op and illegal-op completion: done_valid in cycle 1.
- Throughput: one operation per 4 cycles at best; req_ready is low from the accept cycle+1 until DONE is consumed.
- done_valid and done_ready in the same cycle: the result is consumed and req_ready is 1 in the next cycle.

## Configuration
- YSYX_23060184_LSU_ALIGN_CHECK_EN defined: a misaligned access skips the bus and completes in DONE with fault=1 and rdata=0. Misaligned means HALF/HALFU with addr[0]=1, or WORD with addr[1:0]≠0.
- Macro undefined: no check. WORD ignores addr[1:0]; HALF lane selection uses addr[1] only. The access is issued normally.

## Structure
- Shared defines header holds:
  - Ropcode and Wmask encodings (same names as decode: READ_WORD…READ_BYTEU, WRITE_WORD/HALF/BYTE).
  - LSU state encodings: LSU_IDLE, LSU_REQ, LSU_WAIT, LSU_DONE.
- One combinational sub-module, ysyx_23060184_load_align, takes (data, offset, Ropcode) and produces the extended rdata.

## Test plan
- LW at 0x8000_0004, bus returns 0xDEAD_BEEF with no stalls → mem_addr=0x8000_0004, wstrb=0, rdata=0xDEAD_BEEF, done_valid in cycle 3.
- LB at 0x103, resp 0x80FF_0000 → rdata=0xFFFF_FF80. LBU at the same address → rdata=0x0000_0080.
- SH at 0x202, wdata=0x1234_ABCD → mem_addr=0x200, mem_wdata=0xABCD_ABCD, wstrb=4'b1100, done rdata=0.
- mem_req_ready held low for 3 cycles, then the response arrives with err=1 → mem_req_valid is stable for all stall cycles, and done with fault=1.
- TIMEOUT_CYCLES=4, no response → done_valid with fault=1 after 4 cycles in REQ/WAIT. A late response is not accepted.
- With ALIGN_CHECK_EN, LW at 0x2 → no mem_req_valid, done_valid in cycle 1 with fault=1. rst asserted in WAIT → IDLE next, with no done_valid.
